// File: rtl/job_arbiter_pkg.sv
// Shared types and helpers for the job arbiter: FSM state encoding,
// default watchdog length and a one-hot decoder.
package job_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    FAILED = 2'd2
  } state_t;

  localparam int unsigned DefaultTimeout = 16;

  // Sized for the largest legal requester count; callers truncate.
  function automatic logic [15:0] onehot_from_idx(input int unsigned idx);
    logic [15:0] oh;
    oh = 16'd1 << idx;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NumReq.
module rr_pick #(
  parameter  int unsigned NumReq = 4,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic              valid,
  output logic [IdxW-1:0]   idx
);

  logic [IdxW-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = IdxW'((32'(ptr) + k) % NumReq);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/job_arbiter.sv
// Round-robin job sequencer sharing one worker between NumReq requesters.
// Define JOB_ARBITER_TIMEOUT_EN to enable the BUSY watchdog.
module job_arbiter
  import job_arbiter_pkg::*;
#(
  parameter  int unsigned NumReq        = 4,
  parameter  int unsigned TimeoutCycles = DefaultTimeout,
  localparam int unsigned IdxW          = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic              worker_start_o,
  input  logic              worker_done_i,
  input  logic              worker_err_i,
  output logic              busy_o,
  output logic              failed_o,
  output logic [IdxW-1:0]   fail_idx_o,
  input  logic              clear_i
);

  if (NumReq < 2 || NumReq > 16) begin : g_bad_numreq
    $error("job_arbiter: NumReq must be in 2..16");
  end
  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("job_arbiter: TimeoutCycles must be >= 2");
  end

  state_t            state_q, state_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic              start_q, start_d;
  logic [IdxW-1:0]   win_q, win_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   fidx_q, fidx_d;
  logic [IdxW-1:0]   ptr_next;
  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;
  logic              timeout;

  rr_pick #(
    .NumReq(NumReq)
  ) u_rr_pick (
    .req  (req_i),
    .ptr  (ptr_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  assign ptr_next = (win_q == IdxW'(NumReq - 1)) ? '0 : win_q + IdxW'(1);

`ifdef JOB_ARBITER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter reads k-1 in the k-th BUSY cycle; it is cleared by any non-BUSY cycle.
  assign timeout = (state_q == BUSY) && (cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY) begin
      cnt_d = (cnt_q == CntW'(TimeoutCycles)) ? cnt_q : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    start_d = 1'b0;
    win_d   = win_q;
    ptr_d   = ptr_q;
    fidx_d  = fidx_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          win_d   = pick_idx;
          gnt_d   = NumReq'(onehot_from_idx(32'(pick_idx)));
          start_d = 1'b1;
        end
      end
      BUSY: begin
        // done takes priority over a coinciding timeout; err picks the target.
        if (worker_done_i || timeout) begin
          ptr_d = ptr_next;
          gnt_d = '0;
          if (worker_done_i && !worker_err_i) begin
            state_d = IDLE;
          end else begin
            state_d = FAILED;
            fidx_d  = win_q;
          end
        end
      end
      FAILED: begin
        if (clear_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      start_q <= 1'b0;
      win_q   <= '0;
      ptr_q   <= '0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      fidx_q  <= fidx_d;
    end
  end

  assign gnt_o          = gnt_q;
  assign worker_start_o = start_q;
  assign busy_o         = (state_q == BUSY);
  assign failed_o       = (state_q == FAILED);
  assign fail_idx_o     = fidx_q;

endmodule

// File: tb/tb_job_arbiter.sv
// Directed + randomized bench for job_arbiter against a cycle-level
// behavioural model of the arbitration rules.
module tb_job_arbiter;

  localparam int NumReq  = 4;
  localparam int Timeout = 16;
`ifdef JOB_ARBITER_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NumReq-1:0] req;
  logic [NumReq-1:0] gnt;
  logic              start;
  logic              done;
  logic              err;
  logic              busy;
  logic              failed;
  logic [1:0]        fidx;
  logic              clear;

  job_arbiter #(
    .NumReq(NumReq),
    .TimeoutCycles(Timeout)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .gnt_o         (gnt),
    .worker_start_o(start),
    .worker_done_i (done),
    .worker_err_i  (err),
    .busy_o        (busy),
    .failed_o      (failed),
    .fail_idx_o    (fidx),
    .clear_i       (clear)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: mode 0 idle, 1 running a job, 2 failed.
  int m_mode, m_ptr, m_win, m_fidx, m_bcyc;
  bit m_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; m_win = 0; m_fidx = 0; m_bcyc = 0; m_start = 0;
  endtask

  task automatic model_step(input logic [NumReq-1:0] r, input bit d, input bit e, input bit c);
    m_start = 0;
    case (m_mode)
      0: if (r != 0) begin
        for (int k = NumReq - 1; k >= 0; k--)
          if (r[(m_ptr + k) % NumReq]) m_win = (m_ptr + k) % NumReq;
        m_mode = 1; m_bcyc = 0; m_start = 1;
      end
      1: begin
        m_bcyc++;
        if (d) begin
          m_ptr = (m_win + 1) % NumReq;
          if (e) begin m_mode = 2; m_fidx = m_win; end
          else m_mode = 0;
        end else if (ToEn && m_bcyc == Timeout) begin
          m_mode = 2; m_fidx = m_win; m_ptr = (m_win + 1) % NumReq;
        end
      end
      default: if (c) m_mode = 0;
    endcase
  endtask

  task automatic cycle();
    logic [NumReq-1:0] r;
    logic [3:0] eg;
    bit d, e, c;
    r = req; d = done; e = err; c = clear;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(r, d, e, c);
    #1;
    eg = (m_mode == 1) ? 4'(1 << m_win) : 4'b0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("start", 32'(start), 32'(m_start));
    chk("busy", 32'(busy), 32'(m_mode == 1));
    chk("failed", 32'(failed), 32'(m_mode == 2));
    chk("fail_idx", 32'(fidx), 32'(m_fidx));
  endtask

  function automatic int gnt_idx(input logic [NumReq-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < NumReq; i++) if (g[i]) r = i;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    model_reset();
    rst_n = 1'b0; req = '0; done = 1'b0; err = 1'b0; clear = 1'b0;
    repeat (3) cycle();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    cycle();

    // Single job on requester 0.
    req = 4'b0001; cycle();
    chk("basic_start", 32'(start), 32'h1);
    chk("basic_gnt", 32'(gnt), 32'h1);
    req = '0; cycle();
    chk("basic_start_once", 32'(start), 32'h0);
    cycle();
    done = 1'b1; cycle(); done = 1'b0;
    chk("basic_idle", 32'(busy), 32'h0);
    req = 4'b1111; cycle();
    chk("ptr_after_0", 32'(gnt), 32'h2);

    // Asynchronous reset in the start cycle.
    rst_n = 1'b0; #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_start", 32'(start), 32'h0);
    model_reset();
    cycle(); cycle();
    rst_n = 1'b1;

    // Fairness: all requesting, done 3 cycles after each start.
    for (int j = 0; j < 5; j++) begin
      int w;
      w = 0;
      while (start !== 1'b1 && w < 10) begin cycle(); w++; end
      chk("fair_start_seen", 32'(start), 32'h1);
      chk("fair_gap", 32'(w), 32'h1);
      order.push_back(gnt_idx(gnt));
      repeat (3) cycle();
      done = 1'b1; cycle(); done = 1'b0;
    end
    for (int j = 0; j < 5; j++) chk("fair_order", 32'(order[j]), 32'(exp_order[j]));

    // Error on requester 2.
    req = 4'b0100; cycle();
    chk("err_gnt", 32'(gnt), 32'h4);
    req = '0; done = 1'b1; err = 1'b1; cycle(); done = 1'b0; err = 1'b0;
    chk("err_failed", 32'(failed), 32'h1);
    chk("err_fidx", 32'(fidx), 32'h2);
    req = 4'b1111; done = 1'b1; repeat (3) cycle(); done = 1'b0;
    chk("err_sticky", 32'(failed), 32'h1);
    chk("err_no_gnt", 32'(gnt), 32'h0);
    req = 4'b1000; clear = 1'b1; cycle(); clear = 1'b0;
    chk("clear_idle", 32'(failed), 32'h0);
    cycle();
    chk("after_clear_gnt", 32'(gnt), 32'h8);
    req = '0;

    // Watchdog behaviour on the job for requester 3 (now in BUSY cycle 1).
`ifdef JOB_ARBITER_TIMEOUT_EN
    repeat (15) cycle();
    chk("to_busy_16", 32'(busy), 32'h1);
    cycle();
    chk("to_failed", 32'(failed), 32'h1);
    chk("to_fidx", 32'(fidx), 32'h3);
    clear = 1'b1; cycle(); clear = 1'b0;
    req = 4'b0001; cycle();
    chk("to2_gnt", 32'(gnt), 32'h1);
    req = '0; repeat (15) cycle();
    done = 1'b1; cycle(); done = 1'b0;
    chk("done_on_16_busy", 32'(busy), 32'h0);
    chk("done_on_16_failed", 32'(failed), 32'h0);
`else
    repeat (100) cycle();
    chk("no_to_busy", 32'(busy), 32'h1);
    done = 1'b1; cycle(); done = 1'b0;
    chk("no_to_idle", 32'(busy), 32'h0);
`endif

    // Wrap-around from pointer 3 and a stray done in IDLE.
    req = 4'b0100; cycle(); req = '0;
    done = 1'b1; cycle(); done = 1'b0;
    done = 1'b1; cycle(); done = 1'b0;
    chk("stray_busy", 32'(busy), 32'h0);
    chk("stray_failed", 32'(failed), 32'h0);
    req = 4'b0011; cycle();
    chk("wrap_gnt", 32'(gnt), 32'h1);
    req = '0; done = 1'b1; cycle(); done = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      req   = 4'($urandom_range(0, 15));
      done  = ($urandom_range(0, 3) == 0);
      err   = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
